// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer sitting in front of a UART transmitter.
// Bytes are queued by host logic and launched one at a time over the DV / active / done handshake.
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int GAP_CLKS = 0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Wr_En,
  input  logic [7:0]      i_Wr_Byte,
  input  logic            i_Flush,
  output logic            o_Full,
  output logic            o_Empty,
  output logic [ADDR_W:0] o_Count,
  output logic            o_Overflow,
  output logic            o_Busy,
  output logic            o_Tx_DV,
  output logic [7:0]      o_Tx_Byte,
  input  logic            i_Tx_Active,
  input  logic            i_Tx_Done
);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACTIVE = 2'd1,
    S_WAIT_DONE   = 2'd2
  } state_t;

  localparam ptr_t        PTR_ZERO = ptr_t'(0);
  localparam ptr_t        PTR_ONE  = ptr_t'(1);
  localparam cnt_t        CNT_ZERO = cnt_t'(0);
  localparam cnt_t        CNT_ONE  = cnt_t'(1);
  localparam cnt_t        CNT_FULL = cnt_t'(DEPTH);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CLKS);

  logic [7:0]  mem_r [DEPTH];
  ptr_t        wr_ptr_r;
  ptr_t        rd_ptr_r;
  cnt_t        count_next_s;
  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] gap_r;
  logic        push_s;
  logic        pop_s;
  logic        gap_load_s;

  // Write qualification and next FIFO occupancy
  always_comb begin
    push_s       = i_Wr_En && !o_Full && !i_Flush;
    count_next_s = o_Count;
    if (i_Flush) begin
      count_next_s = CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = o_Count + CNT_ONE;
        2'b01:   count_next_s = o_Count - CNT_ONE;
        default: count_next_s = o_Count;
      endcase
    end
  end

  // Launch sequencer next-state; the done guard in idle blocks a relaunch on the second done cycle
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    gap_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!o_Empty && !i_Tx_Active && !i_Tx_Done && (gap_r == 16'd0)) begin
          pop_s        = 1'b1;
          state_next_s = S_WAIT_ACTIVE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WAIT_ACTIVE: begin
        if (i_Tx_Active) begin
          state_next_s = S_WAIT_DONE;
        end else begin
          state_next_s = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          gap_load_s   = 1'b1;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_WAIT_DONE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pointers, flags, gap counter and transmitter-facing outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      o_Count    <= CNT_ZERO;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
      o_Busy     <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      gap_r      <= 16'd0;
    end else begin
      if (i_Flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      o_Count    <= count_next_s;
      o_Full     <= (count_next_s == CNT_FULL);
      o_Empty    <= (count_next_s == CNT_ZERO);
      o_Overflow <= i_Wr_En && o_Full && !i_Flush;
      o_Busy     <= (count_next_s != CNT_ZERO) || (state_next_s != S_IDLE);
      o_Tx_DV    <= pop_s;
      if (pop_s) begin
        o_Tx_Byte <= mem_r[rd_ptr_r];
      end
      if (gap_load_s) begin
        gap_r <= GAP_LOAD;
      end else if ((state_r == S_IDLE) && (gap_r != 16'd0)) begin
        gap_r <= gap_r - 16'd1;
      end
    end
  end

  // Byte storage; contents are don't-care until written
  always_ff @(posedge i_Clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_Wr_Byte;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a GAP_CLKS=0 instance for the main tests and a
// GAP_CLKS=100 instance for inter-byte gap timing, each driven by a small transmitter model.
module tb_uart_tx_feeder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, flush, tx_stall;
  logic [7:0] wr_byte;
  logic       full, empty, ovf, busy, dv, tx_active;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       g_wr;
  logic [7:0] g_byte;
  logic       g_full, g_empty, g_ovf, g_busy, g_dv;
  logic [4:0] g_count;
  logic [7:0] g_tx_byte;

  int         tx_phase, tx_timer, g_phase, g_timer;
  logic       tx_act, tx_done, g_act, g_done;
  logic [9:0] line_r;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         dv_cnt = 0;
  int         max_count = 0;
  int         last_done_cyc = 0;
  logic       have_done = 1'b0;
  logic       prev_dv = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] sb[$];

  assign tx_active = tx_act | tx_stall;

  uart_tx_feeder #(.DEPTH(16), .GAP_CLKS(0)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_En(wr_en), .i_Wr_Byte(wr_byte), .i_Flush(flush),
    .o_Full(full), .o_Empty(empty), .o_Count(count), .o_Overflow(ovf), .o_Busy(busy),
    .o_Tx_DV(dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  uart_tx_feeder #(.DEPTH(16), .GAP_CLKS(100)) u_gap (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_En(g_wr), .i_Wr_Byte(g_byte), .i_Flush(1'b0),
    .o_Full(g_full), .o_Empty(g_empty), .o_Count(g_count), .o_Overflow(g_ovf), .o_Busy(g_busy),
    .o_Tx_DV(g_dv), .o_Tx_Byte(g_tx_byte), .i_Tx_Active(g_act), .i_Tx_Done(g_done)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dv"}, dv, 0);
    check({tag, "_byte"}, tx_byte, 8'h00);
    check({tag, "_full"}, full, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_count"}, count, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_byte = first + 8'(i);
      sb.push_back(first + 8'(i));
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || tx_phase != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, n < budget, 1);
  endtask

  task automatic wait_tx_active(input string tag);
    int n;
    n = 0;
    while (tx_phase != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_started"}, n < 50, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: active one cycle after DV for 10 bit times, then done high for 2 cycles
  initial begin
    tx_phase = 0; tx_timer = 0; tx_act = 1'b0; tx_done = 1'b0; line_r = 10'd0;
    forever begin
      @(posedge clk);
      case (tx_phase)
        0: if (dv) begin #1; tx_act = 1'b1; tx_timer = 0; tx_phase = 1; end
        1: begin
          if (tx_timer == 0) line_r[0] = 1'b0;
          else if (tx_timer == 9) line_r[9] = 1'b1;
          else line_r[tx_timer] = tx_byte[tx_timer-1];
          #1;
          if (tx_timer == 9) begin tx_act = 1'b0; tx_done = 1'b1; tx_phase = 2; end
          else tx_timer++;
        end
        2: begin #1; tx_phase = 3; end
        default: begin #1; tx_done = 1'b0; tx_phase = 0; end
      endcase
    end
  end

  initial begin
    g_phase = 0; g_timer = 0; g_act = 1'b0; g_done = 1'b0;
    forever begin
      @(posedge clk);
      case (g_phase)
        0: if (g_dv) begin #1; g_act = 1'b1; g_timer = 0; g_phase = 1; end
        1: begin
          #1;
          if (g_timer == 9) begin g_act = 1'b0; g_done = 1'b1; g_phase = 2; end
          else g_timer++;
        end
        2: begin #1; g_phase = 3; end
        default: begin #1; g_done = 1'b0; g_phase = 0; end
      endcase
    end
  end

  // Monitor: every launch is compared against the scoreboard head and the handshake rules
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (int'(count) > max_count) max_count = int'(count);
      if (tx_done && !prev_done) begin
        last_done_cyc = cyc;
        have_done = 1'b1;
      end
      if (dv) begin
        dv_cnt++;
        check("sb_nonempty_at_dv", sb.size() != 0, 1);
        if (sb.size() != 0) check("tx_byte_order", tx_byte, sb.pop_front());
        check("dv_while_tx_idle", tx_phase, 0);
        check("dv_single_cycle", prev_dv, 0);
        if (have_done) check("dv_after_done_min2", (cyc - last_done_cyc) >= 2, 1);
      end
      prev_dv = dv;
      prev_done = tx_done;
    end
  end

  initial begin
    int dv_base, n, ndv, done_cyc;
    int dvc[2];
    logic [7:0] gbytes[2];
    logic pd;

    rst = 1'b1; wr_en = 1'b0; wr_byte = 8'h00; flush = 1'b0; tx_stall = 1'b0;
    g_wr = 1'b0; g_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single byte: push at N, empty falls at N+1, DV with the byte at N+2
    repeat (5) @(posedge clk);
    #1; wr_en = 1'b1; wr_byte = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    check("single_n_dv", dv, 0);
    check("single_n_empty", empty, 1);
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    check("single_n1_empty", empty, 0);
    check("single_n1_count", count, 1);
    check("single_n1_dv", dv, 0);
    @(negedge clk);
    check("single_n2_dv", dv, 1);
    check("single_n2_byte", tx_byte, 8'hA5);
    check("single_n2_empty", empty, 1);
    check("single_n2_busy", busy, 1);
    @(negedge clk);
    check("single_n3_dv", dv, 0);
    wait_idle("single", 100);
    check("single_line", line_r, 10'h34A);

    // Burst to full with the transmitter held busy, then one dropped write
    tx_stall = 1'b1;
    push_seq(8'h00, 16);
    @(negedge clk);
    check("burst_full", full, 1);
    check("burst_count16", count, 16);
    check("burst_not_empty", empty, 0);
    check("burst_no_ovf_yet", ovf, 0);
    @(posedge clk); #1; wr_en = 1'b1; wr_byte = 8'h10;
    @(negedge clk);
    check("ovf_same_cycle", ovf, 0);
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    check("ovf_pulse", ovf, 1);
    check("ovf_count_kept", count, 16);
    @(negedge clk);
    check("ovf_single_pulse", ovf, 0);
    dv_base = dv_cnt;
    tx_stall = 1'b0;
    wait_idle("burst", 1000);
    check("burst_dv_count", dv_cnt - dv_base, 16);
    check("burst_sb_drained", sb.size(), 0);
    check("burst_busy_low", busy, 0);
    check("burst_empty", empty, 1);

    // Pointer wrap: 40 bytes in mixed bursts
    max_count = 0;
    dv_base = dv_cnt;
    push_seq(8'h40, 7);
    repeat (20) @(posedge clk);
    push_seq(8'h47, 9);
    @(negedge clk);
    wait_idle("wrap_a", 600);
    push_seq(8'h50, 13);
    @(negedge clk);
    wait_idle("wrap_b", 600);
    push_seq(8'h5D, 11);
    @(negedge clk);
    wait_idle("wrap_c", 600);
    check("wrap_dv_count", dv_cnt - dv_base, 40);
    check("wrap_max_count_le16", max_count <= 16, 1);
    check("wrap_sb_drained", sb.size(), 0);

    // Flush during the first byte's transmission, with a write in the same cycle
    dv_base = dv_cnt;
    push_seq(8'h81, 5);
    wait_tx_active("flush");
    @(posedge clk); #1; flush = 1'b1; wr_en = 1'b1; wr_byte = 8'hEE;
    @(posedge clk); #1; flush = 1'b0; wr_en = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_no_ovf", ovf, 0);
    check("flush_inflight_byte", tx_byte, 8'h81);
    wait_idle("flush", 200);
    check("flush_dv_count", dv_cnt - dv_base, 1);
    check("flush_count_end", count, 0);

    // Asynchronous reset while a byte is in flight, then relaunch only once the transmitter is idle
    push_seq(8'h33, 1);
    wait_tx_active("rstmid");
    repeat (2) @(posedge clk);
    #3; rst = 1'b1;
    #1; check_idle("async_reset");
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    dv_base = dv_cnt;
    push_seq(8'h5A, 1);
    @(negedge clk);
    wait_idle("rstmid", 200);
    check("rstmid_dv_count", dv_cnt - dv_base, 1);
    check("rstmid_sb_drained", sb.size(), 0);

    // Gap instance: second DV no earlier than done rise + 2 + 100
    @(posedge clk); #1; g_wr = 1'b1; g_byte = 8'hC1;
    @(posedge clk); #1; g_byte = 8'hC2;
    @(posedge clk); #1; g_wr = 1'b0;
    n = 0; ndv = 0; done_cyc = -1; pd = 1'b0;
    gbytes[0] = 8'h00; gbytes[1] = 8'h00; dvc[0] = 0; dvc[1] = 0;
    while (ndv < 2 && n < 400) begin
      @(negedge clk);
      n++;
      if (g_done && !pd && done_cyc < 0) done_cyc = cyc;
      pd = g_done;
      if (g_dv) begin
        gbytes[ndv] = g_tx_byte;
        dvc[ndv] = cyc;
        ndv++;
      end
    end
    check("gap_two_dvs", ndv, 2);
    check("gap_byte0", gbytes[0], 8'hC1);
    check("gap_byte1", gbytes[1], 8'hC2);
    check("gap_spacing_min102", (dvc[1] - done_cyc) >= 102, 1);
    check("gap_spacing_max104", (dvc[1] - done_cyc) <= 104, 1);

    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter. It buffers bytes written by the host-side logic and hands them to the transmitter one at a time over the transmitter's data-valid / active / done handshake. Each byte is launched only after the previous one has fully completed. The block lets register-bank or protocol logic burst a whole frame without polling the transmitter.

## Interface
- DEPTH, 16: FIFO depth in bytes; power of two, 2..256.
- ADDR_W, $clog2(DEPTH): pointer width.
- GAP_CLKS, 0: idle clocks inserted between the previous byte's done and the next DV; 0..65535.

- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Wr_En  in  1  push i_Wr_Byte this cycle.
- i_Wr_Byte  in  8  byte to push.
- i_Flush  in  1  discard all queued bytes.
- o_Full  out  1  FIFO holds DEPTH bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Count  out  ADDR_W+1  bytes queued (excludes byte in flight).
- o_Overflow  out  1  one-cycle pulse: a write was dropped.
- o_Busy  out  1  FIFO non-empty or FSM not in S_IDLE.
- o_Tx_DV  out  1  one-cycle launch pulse to transmitter.
- o_Tx_Byte  out  8  byte for transmitter; stable from DV until done.
- i_Tx_Active  in  1  transmitter active flag.
- i_Tx_Done  in  1  transmitter done flag (may stay high 2 cycles).

## Operation
- FIFO: circular buffer with ADDR_W-bit pointers and an (ADDR_W+1)-bit count. Pointers wrap DEPTH-1 -> 0.
- Write accepted iff i_Wr_En && !o_Full && !i_Flush.
- Write while full is dropped and pulses o_Overflow on the next cycle, even if a pop happens the same cycle.
- Pop occurs only in the cycle the FSM leaves S_IDLE. Simultaneous push and pop leaves count unchanged.
- i_Flush: resets pointers and count. A write in the same cycle is discarded, with no o_Overflow. It does not abort the byte in flight.
- FSM states:
  - S_IDLE: if !o_Empty && !i_Tx_Active && !i_Tx_Done && gap counter == 0: pop the head into o_Tx_Byte, set o_Tx_DV, go to S_WAIT_ACTIVE.
  - S_WAIT_ACTIVE: o_Tx_DV returns 0. Go to S_WAIT_DONE when i_Tx_Active == 1.
  - S_WAIT_DONE: on i_Tx_Done == 1, load the gap counter with GAP_CLKS and go to S_IDLE.
- Gap counter: 16-bit down-counter; decrements in S_IDLE while non-zero.
- The !i_Tx_Done guard in S_IDLE stops a relaunch during the second done cycle. It also makes the block safe after a reset taken while the transmitter is mid-byte: no DV is issued until the transmitter is idle.
- Reset values: o_Tx_DV 0, o_Tx_Byte 8'h00, o_Full 0, o_Empty 1, o_Count 0, o_Overflow 0, o_Busy 0; FSM in S_IDLE; gap counter 0; pointers 0.
- Reset mid-operation: the FIFO contents are lost, and reset takes effect asynchronously.

## Timing
- All outputs are registered.
- Push to launch latency into an empty, idle block: write at cycle N; o_Empty falls at N+1; o_Tx_DV high with o_Tx_Byte valid at N+2.
- o_Tx_DV is exactly one cycle wide. o_Tx_Byte changes only at a launch.
- Back-to-back with GAP_CLKS = 0: i_Tx_Done first seen high at cycle M; FSM in S_IDLE at M+1, where the launch is blocked by i_Tx_Done still high; next o_Tx_DV at M+2 or later.
- With GAP_CLKS = G, the next o_Tx_DV is no earlier than M+2+G.
- o_Count, o_Full and o_Empty update the cycle after the push, pop or flush.

## Test plan
- Reset mid-frame: assert i_Reset while a byte is in flight; all outputs show reset values immediately. Then push 8'h5A; no DV until the transmitter finishes and i_Tx_Done falls, then exactly one DV carrying 8'h5A.
- Single byte: push 8'hA5 at cycle 10; o_Tx_DV is high only at cycle 12 with o_Tx_Byte = 8'hA5. The transmitter line shows 0,1,0,1,0,0,1,0,1 then the stop bit (LSB first).
- Burst: with DEPTH = 16, push 16 bytes 0x00..0x0F back-to-back; o_Full = 1 after the 16th. A 17th push pulses o_Overflow once with count unchanged. All 16 bytes are transmitted in order, with exactly one DV per byte, and o_Busy falls after the last done.
- Pointer wrap: push and drain 40 bytes in mixed bursts; output order matches input, and o_Count never exceeds 16.
- Gap: with GAP_CLKS = 100, two queued bytes; the second DV comes no earlier than 102 cycles after the first i_Tx_Done rise.
- Flush: queue 5 bytes, assert i_Flush during the first byte's transmission; that byte completes, no further DV is issued, o_Count = 0 and o_Empty = 1.
